// File: rtl/jesd204_rx_sync_pkg.sv
// ============================================================================
// Module      : jesd204_rx_sync_pkg
// Description : Shared link-state encodings for the JESD204B RX SYNC~ generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jesd204_rx_sync_pkg;

    localparam int STATE_W = 2;

    // 2'b11 is unused and is treated as CGS by the link FSM
    typedef enum logic [STATE_W-1:0] {
        ST_CGS       = 2'b00,
        ST_WAIT_LMFC = 2'b01,
        ST_DATA      = 2'b10
    } link_state_e;

endpackage

`default_nettype wire

// File: rtl/jesd204_rx_sync_link.sv
// ============================================================================
// Module      : jesd204_rx_sync_link
// Description : Per-link SYNC~ FSM, saturating error counter and optional
//               error-report pulse (enabled by JESD204_SYNC_ERR_REPORT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jesd204_rx_sync_link
    import jesd204_rx_sync_pkg::*;
#(
    parameter int ERR_CNT_WIDTH    = 8,
    parameter int ERR_REPORT_BEATS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     lmfc_edge_i,
    input  logic                     link_ready_i,
    input  logic                     link_err_i,
    input  logic                     link_disable_i,
    input  logic [ERR_CNT_WIDTH-1:0] err_threshold_i,
    input  logic                     manual_req_i,
    output logic                     sync_o,
    output logic [STATE_W-1:0]       state_o,
    output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

    localparam logic [ERR_CNT_WIDTH-1:0] C_CNT_MAX = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] C_CNT_ONE = ERR_CNT_WIDTH'(1);

    if (ERR_REPORT_BEATS < 1) begin : g_bad_beats
        $error("ERR_REPORT_BEATS must be at least 1");
    end

    link_state_e              state_q, state_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ERR_CNT_WIDTH-1:0] w_cnt_sat;
    logic                     sync_q, sync_d;
    logic                     w_pulse_low;

    // Priority: manual request > ready loss > error threshold > LMFC advance
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_cnt_sat = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + C_CNT_ONE;
        case (state_q)
            ST_WAIT_LMFC: begin
                if (manual_req_i || !link_ready_i) begin
                    state_d = ST_CGS;
                end else if (lmfc_edge_i) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (link_err_i) begin
                    cnt_d = w_cnt_sat;
                end
                if (manual_req_i || !link_ready_i) begin
                    state_d = ST_CGS;
                end else if ((err_threshold_i != '0) && (cnt_d >= err_threshold_i)) begin
                    state_d = ST_CGS;
                end
            end
            default: begin
                state_d = (link_ready_i && !manual_req_i) ? ST_WAIT_LMFC : ST_CGS;
            end
        endcase
        if (link_disable_i) begin
            state_d = ST_CGS;
        end
        // Counter is cleared in the same update that enters CGS
        if (state_d == ST_CGS) begin
            cnt_d = '0;
        end
    end

`ifdef JESD204_SYNC_ERR_REPORT_EN
    localparam int                  PULSE_W     = $clog2(ERR_REPORT_BEATS + 1);
    localparam logic [PULSE_W-1:0]  C_PULSE_LEN = PULSE_W'(ERR_REPORT_BEATS);
    localparam logic [PULSE_W-1:0]  C_PULSE_ONE = PULSE_W'(1);

    logic [PULSE_W-1:0] pulse_q, pulse_d;

    // Pulse runs only while the link stays in DATA; errors inside it never restart it
    always_comb begin
        pulse_d = '0;
        if (!link_disable_i && (state_q == ST_DATA) && (state_d == ST_DATA)) begin
            if (pulse_q != '0) begin
                pulse_d = pulse_q - C_PULSE_ONE;
            end else if (link_err_i) begin
                pulse_d = C_PULSE_LEN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign w_pulse_low = (pulse_d != '0);
`else
    assign w_pulse_low = 1'b0;
`endif

    assign sync_d = link_disable_i | ((state_d == ST_DATA) & ~w_pulse_low);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_CGS;
            cnt_q   <= '0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
        end
    end

    assign sync_o      = sync_q;
    assign state_o     = state_q;
    assign err_count_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/jesd204_rx_sync_gen.sv
// ============================================================================
// Module      : jesd204_rx_sync_gen
// Description : JESD204B RX SYNC~ generator; reduces lane status to links and
//               runs one link FSM per link. Option: JESD204_SYNC_ERR_REPORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jesd204_rx_sync_gen
    import jesd204_rx_sync_pkg::*;
#(
    parameter int NUM_LANES        = 4,
    parameter int NUM_LINKS        = 2,
    parameter int ERR_CNT_WIDTH    = 8,
    parameter int ERR_REPORT_BEATS = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               lmfc_edge,
    input  logic [NUM_LANES-1:0]               lane_cgs_done,
    input  logic [NUM_LANES-1:0]               lane_err,
    input  logic [NUM_LANES-1:0]               cfg_lanes_disable,
    input  logic [NUM_LINKS-1:0]               cfg_links_disable,
    input  logic [ERR_CNT_WIDTH-1:0]           cfg_err_threshold,
    input  logic                               ctrl_manual_sync_request,
    output logic [NUM_LINKS-1:0]               sync,
    output logic [STATE_W*NUM_LINKS-1:0]       status_state,
    output logic [ERR_CNT_WIDTH*NUM_LINKS-1:0] status_err_count
);

    localparam int LANES_PER_LINK = NUM_LANES / NUM_LINKS;

    if ((NUM_LANES % NUM_LINKS) != 0) begin : g_bad_lane_split
        $error("NUM_LANES must be an integer multiple of NUM_LINKS");
    end

    for (genvar k = 0; k < NUM_LINKS; k++) begin : g_link
        logic w_link_ready;
        logic w_link_err;

        // Disabled lanes count as ready and never report errors
        assign w_link_ready = &(lane_cgs_done[k*LANES_PER_LINK +: LANES_PER_LINK] |
                                cfg_lanes_disable[k*LANES_PER_LINK +: LANES_PER_LINK]);
        assign w_link_err   = |(lane_err[k*LANES_PER_LINK +: LANES_PER_LINK] &
                                ~cfg_lanes_disable[k*LANES_PER_LINK +: LANES_PER_LINK]);

        jesd204_rx_sync_link #(
            .ERR_CNT_WIDTH    (ERR_CNT_WIDTH),
            .ERR_REPORT_BEATS (ERR_REPORT_BEATS)
        ) u_link (
            .clk             (clk),
            .reset           (reset),
            .lmfc_edge_i     (lmfc_edge),
            .link_ready_i    (w_link_ready),
            .link_err_i      (w_link_err),
            .link_disable_i  (cfg_links_disable[k]),
            .err_threshold_i (cfg_err_threshold),
            .manual_req_i    (ctrl_manual_sync_request),
            .sync_o          (sync[k]),
            .state_o         (status_state[k*STATE_W +: STATE_W]),
            .err_count_o     (status_err_count[k*ERR_CNT_WIDTH +: ERR_CNT_WIDTH])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_jesd204_rx_sync_gen.sv
// ============================================================================
// Module      : tb_jesd204_rx_sync_gen
// Description : Self-checking bench for jesd204_rx_sync_gen with a per-cycle
//               reference model feeding a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jesd204_rx_sync_gen;

    localparam int NL    = 2;
    localparam int NLANE = 4;
    localparam int LPL   = NLANE / NL;
    localparam int CW    = 8;
    localparam int BEATS = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             lmfc_edge;
    logic [NLANE-1:0] lane_cgs_done;
    logic [NLANE-1:0] lane_err;
    logic [NLANE-1:0] cfg_lanes_disable;
    logic [NL-1:0]    cfg_links_disable;
    logic [CW-1:0]    cfg_err_threshold;
    logic             ctrl_manual_sync_request;
    logic [NL-1:0]    sync;
    logic [2*NL-1:0]  status_state;
    logic [CW*NL-1:0] status_err_count;

    jesd204_rx_sync_gen #(
        .NUM_LANES        (NLANE),
        .NUM_LINKS        (NL),
        .ERR_CNT_WIDTH    (CW),
        .ERR_REPORT_BEATS (BEATS)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .lmfc_edge                (lmfc_edge),
        .lane_cgs_done            (lane_cgs_done),
        .lane_err                 (lane_err),
        .cfg_lanes_disable        (cfg_lanes_disable),
        .cfg_links_disable        (cfg_links_disable),
        .cfg_err_threshold        (cfg_err_threshold),
        .ctrl_manual_sync_request (ctrl_manual_sync_request),
        .sync                     (sync),
        .status_state             (status_state),
        .status_err_count         (status_err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL-1:0]    sync;
        logic [2*NL-1:0]  st;
        logic [CW*NL-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   lmfc_cnt = 0;

    int   m_st   [NL];
    int   m_cnt  [NL];
    int   m_pulse[NL];
    bit   m_sync [NL];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NL; k++) begin
            m_st[k] = 0; m_cnt[k] = 0; m_pulse[k] = 0; m_sync[k] = 1'b0;
        end
    endtask

    // Predicts the registered outputs after the coming clock edge
    task automatic model_step();
        exp_t e;
        if (reset) begin
            model_reset();
        end else begin
            for (int k = 0; k < NL; k++) begin
                bit rdy, er;
                int nst, ncnt, npl;
                rdy = 1'b1; er = 1'b0;
                for (int l = k*LPL; l < (k+1)*LPL; l++) begin
                    if (!cfg_lanes_disable[l]) begin
                        rdy = rdy & lane_cgs_done[l];
                        er  = er | lane_err[l];
                    end
                end
                if (cfg_links_disable[k]) begin
                    m_st[k] = 0; m_cnt[k] = 0; m_pulse[k] = 0; m_sync[k] = 1'b1;
                    continue;
                end
                nst  = m_st[k];
                ncnt = m_cnt[k];
                if (m_st[k] == 2 && er) ncnt = (ncnt < CMAX) ? ncnt + 1 : CMAX;
                if (ctrl_manual_sync_request)                                   nst = 0;
                else if (m_st[k] != 1 && m_st[k] != 2)                          nst = rdy ? 1 : 0;
                else if (!rdy)                                                  nst = 0;
                else if (m_st[k] == 2 && cfg_err_threshold != 0 &&
                         ncnt >= int'(cfg_err_threshold))                       nst = 0;
                else if (m_st[k] == 1 && lmfc_edge)                             nst = 2;
                if (nst == 0) ncnt = 0;
                npl = 0;
`ifdef JESD204_SYNC_ERR_REPORT_EN
                if (m_st[k] == 2 && nst == 2) begin
                    if (m_pulse[k] > 0) npl = m_pulse[k] - 1;
                    else if (er)        npl = BEATS;
                end
`endif
                m_st[k] = nst; m_cnt[k] = ncnt; m_pulse[k] = npl;
                m_sync[k] = (nst == 2) && (npl == 0);
            end
        end
        for (int k = 0; k < NL; k++) begin
            e.sync[k]          = m_sync[k];
            e.st[2*k +: 2]     = 2'(m_st[k]);
            e.cnt[CW*k +: CW]  = CW'(m_cnt[k]);
        end
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            lmfc_edge = (lmfc_cnt == 31);
            lmfc_cnt  = (lmfc_cnt + 1) % 32;
            model_step();
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            check("sb_sync",  32'(sync),             32'(e.sync));
            check("sb_state", 32'(status_state),     32'(e.st));
            check("sb_count", 32'(status_err_count), 32'(e.cnt));
        end
    endtask

    task automatic wait_sync(input logic [NL-1:0] exp, input string tag);
        int n;
        n = 0;
        while (sync !== exp && n < 40) begin
            tick(1);
            n++;
        end
        check(tag, 32'(sync), 32'(exp));
    endtask

    initial begin
        reset = 1'b1;
        lmfc_edge = 1'b0;
        lane_cgs_done = '1;
        lane_err = '0;
        cfg_lanes_disable = '0;
        cfg_links_disable = '0;
        cfg_err_threshold = '0;
        ctrl_manual_sync_request = 1'b0;
        model_reset();
        #2;
        check("rst_sync",  32'(sync), 32'h0);
        check("rst_state", 32'(status_state), 32'h0);
        check("rst_count", 32'(status_err_count), 32'h0);
        tick(3);
        reset = 1'b0;

        // Bring-up: both links reach DATA after the first LMFC edge
        wait_sync(2'b11, "bringup_sync");
        check("bringup_state", 32'(status_state), 32'hA);

        // Lane 2 loses lock: only link 1 drops to CGS
        lane_cgs_done = 4'b1011;
        tick(1);
        check("lockloss_sync", 32'(sync), 32'h1);
        check("lockloss_st1",  32'(status_state[3:2]), 32'h0);
        lane_cgs_done = '1;
        wait_sync(2'b11, "relock_sync");

        // Error threshold of 3 on link 0
        cfg_err_threshold = 8'd3;
        for (int p = 1; p <= 3; p++) begin
            lane_err = 4'b0001;
            tick(1);
            lane_err = '0;
            if (p < 3) begin
                check("thr_count", 32'(status_err_count[7:0]), 32'(p));
            end else begin
                check("thr_resync_sync",  32'(sync[0]), 32'h0);
                check("thr_resync_count", 32'(status_err_count[7:0]), 32'h0);
                check("thr_resync_state", 32'(status_state[1:0]), 32'h0);
            end
            tick(3);
        end
        wait_sync(2'b11, "thr_recover_sync");

        // Threshold disabled: counter saturates, link stays up
        cfg_err_threshold = 8'd0;
        lane_err = 4'b0001;
        tick(300);
        lane_err = '0;
        check("sat_count", 32'(status_err_count[7:0]), 32'd255);
        check("sat_state", 32'(status_state[1:0]), 32'h2);
        tick(3);
        check("sat_sync", 32'(sync), 32'h3);

        // Link 1 disabled, then manual request on link 0
        cfg_links_disable = 2'b10;
        tick(2);
        check("dis_sync1",  32'(sync[1]), 32'h1);
        check("dis_state1", 32'(status_state[3:2]), 32'h0);
        ctrl_manual_sync_request = 1'b1;
        tick(10);
        check("manual_sync0",  32'(sync[0]), 32'h0);
        check("manual_state0", 32'(status_state[1:0]), 32'h0);
        ctrl_manual_sync_request = 1'b0;
        wait_sync(2'b11, "manual_release_sync");
        cfg_links_disable = 2'b00;
        tick(1);
        check("reenable_sync1", 32'(sync[1]), 32'h0);
        wait_sync(2'b11, "reenable_up_sync");

        // Single error in DATA with threshold 0
        lane_err = 4'b0001;
        tick(1);
        lane_err = '0;
`ifdef JESD204_SYNC_ERR_REPORT_EN
        check("pulse_beat1", 32'(sync[0]), 32'h0);
        lane_err = 4'b0001;
        tick(1);
        lane_err = '0;
        check("pulse_beat2", 32'(sync[0]), 32'h0);
        tick(1);
        check("pulse_end", 32'(sync[0]), 32'h1);
`else
        check("noreport_sync", 32'(sync[0]), 32'h1);
        tick(2);
        check("noreport_hold", 32'(sync[0]), 32'h1);
`endif
        tick(2);

        // Asynchronous reset mid-operation
        reset = 1'b1;
        #2;
        model_reset();
        check("async_rst_sync",  32'(sync), 32'h0);
        check("async_rst_state", 32'(status_state), 32'h0);
        check("async_rst_count", 32'(status_err_count), 32'h0);
        tick(2);
        reset = 1'b0;
        wait_sync(2'b11, "post_reset_sync");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jesd204_rx_sync_gen.md
Name: jesd204_rx_sync_gen

Overview:
- Receiver-side SYNC~ generator for the JESD204B link layer; the far-end counterpart of the transmitter's SYNC input.
- Per link: holds SYNC~ low (synchronisation request) until every enabled lane of that link reports code-group-synchronisation (CGS) lock.
- Releases SYNC~ aligned to the next LMFC edge.
- Re-requests synchronisation on lane lock loss, error-threshold overflow or manual request.
- Sits between the per-lane RX CGS/decoder logic and the SYNC~ output pins.

Parameters:
NUM_LANES, 4, total lanes; must be an integer multiple of NUM_LINKS
NUM_LINKS, 2, independent links; lanes split contiguously, LANES_PER_LINK = NUM_LANES/NUM_LINKS (link k owns lanes k*LPL .. k*LPL+LPL-1)
ERR_CNT_WIDTH, 8, width of per-link error counter and threshold
ERR_REPORT_BEATS, 2, SYNC~ error-pulse length in clk cycles (used only with optional feature)

Ports:
clk  in  1  link clock
reset  in  1  asynchronous, active-high reset
lmfc_edge  in  1  single-cycle pulse on each local multiframe clock edge
lane_cgs_done  in  NUM_LANES  level, lane has achieved CGS lock
lane_err  in  NUM_LANES  single-cycle pulse per disparity/not-in-table/unexpected-K error
cfg_lanes_disable  in  NUM_LANES  1 = lane ignored
cfg_links_disable  in  NUM_LINKS  1 = link ignored, SYNC~ forced high
cfg_err_threshold  in  ERR_CNT_WIDTH  error count forcing resync; 0 disables error resync
ctrl_manual_sync_request  in  1  level; forces all links to CGS while high
sync  out  NUM_LINKS  active-low SYNC~ per link
status_state  out  2*NUM_LINKS  per-link state encoding
status_err_count  out  ERR_CNT_WIDTH*NUM_LINKS  per-link error counter

Behaviour:
- Reset values: sync = all 0; status_state = CGS (2'b00) for all links; status_err_count = 0.
- Link inputs:
  - link_ready = AND over owned lanes of (lane_cgs_done | cfg_lanes_disable). A link with all lanes disabled is vacuously ready.
  - link_err = OR over owned enabled lanes of lane_err.
- States per link: CGS=00, WAIT_LMFC=01, DATA=10 (11 unused; decodes to CGS).
- CGS:
  - sync=0, counter cleared.
  - Go to WAIT_LMFC when link_ready=1 and manual request=0.
- WAIT_LMFC:
  - sync=0.
  - On lmfc_edge go to DATA; sync goes 1 in the same registered update, so sync is high the cycle after the lmfc_edge pulse.
  - If link_ready drops, go to CGS.
- DATA:
  - sync=1.
  - Counter += 1 per cycle with link_err, saturating at all-ones.
  - When threshold != 0 and the counter after increment >= threshold, go to CGS.
  - If link_ready drops, go to CGS.
- Manual request: from any state go to CGS next cycle; hold in CGS while asserted.
- Priority within one cycle: manual request > link_ready loss > error threshold > lmfc_edge advance.
- Disabled link: state forced to CGS, counter 0, sync=1. Clearing the disable bit restarts the link from CGS with sync=0 on the next cycle.
- cfg changes mid-operation take effect on the next cycle; no latching.
- Asserting reset mid-operation returns all links to reset values immediately (asynchronous); release is synchronous to clk.
- All outputs are registered; no combinational input-to-output path.

Optional Feature:
- Macro JESD204_SYNC_ERR_REPORT_EN.
- Defined: in DATA, a link_err cycle that does not trigger resync drives that link's sync low for exactly ERR_REPORT_BEATS cycles, starting the next cycle.
  - Errors during the pulse are counted but do not retrigger or extend it.
  - A transition to CGS during the pulse cancels it.
- Undefined: sync stays 1 throughout DATA; errors are only counted.

Decomposition:
- Package jesd204_rx_sync_pkg: state encodings (CGS, WAIT_LMFC, DATA) and the 2-bit state width constant.
- Sub-module jesd204_rx_sync_link: one per link via generate. It contains the FSM, error counter and optional pulse logic.
- Top level handles lane-to-link reduction and output concatenation.

Test Plan:
- Reset, all lanes cgs_done=1, lmfc_edge every 32 cycles → sync[1:0]=00 until the first lmfc_edge after reset release, then 11 the following cycle; status_state=10.
- In DATA, drop lane_cgs_done[2] (link 1) → sync[1]=0 next cycle and status_state link1=00; sync[0] stays 1.
- cfg_err_threshold=3, three lane_err[0] pulses in DATA → status_err_count link0 = 1, 2, then resync: sync[0]=0, counter 0.
- cfg_err_threshold=0, 300 error pulses → counter saturates at 255, sync stays 1.
- cfg_links_disable=2'b10 → sync[1]=1 constantly, status_state link1=00; ctrl_manual_sync_request high for 10 cycles → sync[0]=0 during and until the next lmfc_edge after release.
- With JESD204_SYNC_ERR_REPORT_EN, threshold=0, single lane_err → sync low for exactly 2 cycles, then high; second error inside the pulse does not extend it.
